ex_stage: RTL and testbench

Execute stage of the five-stage LoongArch pipeline, between ID and MEM. Consumes the decoded bundle from ID and computes the ALU, multiply, or iterative-divide result. Drives the EX→MEM pipeline register consumed by MEM and exports a forwarding/stall tap to ID. Division is a 32-iteration restoring FSM that stalls the stage; all other operations complete in one cycle.

---
 rtl/ex_stage_if.sv | 21 ++
 rtl/ex_stage.sv | 197 +++++++++++++++++++
 tb/tb_ex_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// EX stage boundary: ID bundle in, MEM handshake, forwarding tap to ID, EX->MEM register out.
interface ex_stage_if;
  logic [195:0] ID_to_EX_zip;
  logic         MEM_allowin;
  logic         EX_allowin;
  logic         front_valid;
  logic         front_busy;
  logic [4:0]   front_addr;
  logic [31:0]  front_data;
  logic [144:0] EX_to_MEM_reg;

  modport master (
    output ID_to_EX_zip, MEM_allowin,
    input  EX_allowin, front_valid, front_busy, front_addr, front_data, EX_to_MEM_reg
  );

  modport slave (
    input  ID_to_EX_zip, MEM_allowin,
    output EX_allowin, front_valid, front_busy, front_addr, front_data, EX_to_MEM_reg
  );
endinterface

// File: rtl/ex_stage.sv
// LoongArch execute stage: one-cycle ALU and multiply, 32-iteration restoring divider
// that stalls the stage, EX->MEM pipeline register and forwarding tap back to ID.
module ex_stage (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [11:0] alu_op;
    logic [3:0]  div_op;
    logic [2:0]  mul_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  ld_flags;
    logic [2:0]  st_flags;
    logic        mem_we;
    logic        res_from_mem;
    logic        gr_we;
    logic [31:0] rkd_value;
    logic [4:0]  rf_waddr;
  } id_bundle_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  ld_flags;
    logic [2:0]  st_flags;
    logic        mem_we;
    logic        res_from_mem;
    logic        gr_we;
    logic [31:0] rkd_value;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } mem_bundle_t;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_t;

  id_bundle_t id;
  assign id = bus.ID_to_EX_zip;

  // ALU: alu_op[0]=add ... alu_op[11]=lui; an all-zero op falls back to add
  logic [4:0]  sa;
  logic [31:0] add_res, sub_res, slt_res, sltu_res, and_res, nor_res, or_res, xor_res;
  logic [31:0] sll_res, srl_res, sra_res, lui_res, alu_res;

  assign sa       = id.src2[4:0];
  assign add_res  = id.src1 + id.src2;
  assign sub_res  = id.src1 - id.src2;
  assign slt_res  = {31'd0, $signed(id.src1) < $signed(id.src2)};
  assign sltu_res = {31'd0, id.src1 < id.src2};
  assign and_res  = id.src1 & id.src2;
  assign nor_res  = ~(id.src1 | id.src2);
  assign or_res   = id.src1 | id.src2;
  assign xor_res  = id.src1 ^ id.src2;
  assign sll_res  = id.src1 << sa;
  assign srl_res  = id.src1 >> sa;
  assign sra_res  = $signed(id.src1) >>> sa;
  assign lui_res  = id.src2;

  always_comb begin
    alu_res = add_res;
    if (id.alu_op != '0)
      alu_res = ({32{id.alu_op[0]}}  & add_res)  | ({32{id.alu_op[1]}}  & sub_res)  |
                ({32{id.alu_op[2]}}  & slt_res)  | ({32{id.alu_op[3]}}  & sltu_res) |
                ({32{id.alu_op[4]}}  & and_res)  | ({32{id.alu_op[5]}}  & nor_res)  |
                ({32{id.alu_op[6]}}  & or_res)   | ({32{id.alu_op[7]}}  & xor_res)  |
                ({32{id.alu_op[8]}}  & sll_res)  | ({32{id.alu_op[9]}}  & srl_res)  |
                ({32{id.alu_op[10]}} & sra_res)  | ({32{id.alu_op[11]}} & lui_res);
  end

  // Multiply: mul_op = {mul_w, mulh_w, mulh_wu}; low 64 bits of the extended product
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] mul_res;

  assign mul_signed = id.mul_op[2] | id.mul_op[1];
  assign mul_a      = {{32{mul_signed & id.src1[31]}}, id.src1};
  assign mul_b      = {{32{mul_signed & id.src2[31]}}, id.src2};
  assign prod       = mul_a * mul_b;
  assign mul_res    = id.mul_op[2] ? prod[31:0] : prod[63:32];

  // Divide: div_op = {div_w, mod_w, div_wu, mod_wu}
  div_state_t  state, state_nxt;
  logic [5:0]  cnt;
  logic        div_start;
  logic        div_signed;
  logic [31:0] abs1, abs2;
  logic [31:0] dvs, quo, rem;
  logic        q_neg, r_neg, div_zero, is_mod;
  logic [32:0] shifted, trial;
  logic [31:0] quo_fix, rem_fix, div_res;

  assign div_signed = id.div_op[3] | id.div_op[2];
  assign abs1       = (div_signed & id.src1[31]) ? -id.src1 : id.src1;
  assign abs2       = (div_signed & id.src2[31]) ? -id.src2 : id.src2;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      IDLE: if (id.valid && id.div_op != '0) begin
        state_nxt = BUSY;
        div_start = 1'b1;
      end
      BUSY: if (cnt == 6'd31) state_nxt = DONE;
      DONE: if (bus.MEM_allowin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Partial remainder shifts in one dividend bit per cycle; quo doubles as dividend/quotient
  assign shifted = {rem, quo[31]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      is_mod   <= 1'b0;
    end else if (div_start) begin
      cnt      <= '0;
      dvs      <= abs2;
      quo      <= abs1;
      rem      <= '0;
      q_neg    <= div_signed & (id.src1[31] ^ id.src2[31]);
      r_neg    <= div_signed & id.src1[31];
      div_zero <= (id.src2 == '0);
      is_mod   <= id.div_op[2] | id.div_op[0];
    end else if (state == BUSY) begin
      cnt <= cnt + 6'd1;
      if (!trial[32]) begin
        rem <= trial[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= shifted[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  // Zero divisor leaves remainder = |src1| which the sign fix turns back into src1
  assign quo_fix = div_zero ? 32'hFFFF_FFFF : (q_neg ? -quo : quo);
  assign rem_fix = r_neg ? -rem : rem;
  assign div_res = is_mod ? rem_fix : quo_fix;

  logic [31:0] ex_result;
  logic        ready_go;

  assign ex_result = (id.div_op != '0) ? div_res :
                     (id.mul_op != '0) ? mul_res : alu_res;
  assign ready_go  = id.valid & ((id.div_op == '0) | (state == DONE));

  assign bus.EX_allowin  = ~id.valid | (ready_go & bus.MEM_allowin);
  assign bus.front_valid = id.valid & id.gr_we & ~id.res_from_mem & ready_go;
  assign bus.front_busy  = id.valid & id.gr_we & (id.res_from_mem | ~ready_go);
  assign bus.front_addr  = id.rf_waddr;
  assign bus.front_data  = ex_result;

  mem_bundle_t mem_nxt, mem_q;

  always_comb begin
    mem_nxt              = '0;
    mem_nxt.valid        = id.valid;
    mem_nxt.pc           = id.pc;
    mem_nxt.ir           = id.ir;
    mem_nxt.ld_flags     = id.ld_flags;
    mem_nxt.st_flags     = id.st_flags;
    mem_nxt.mem_we       = id.mem_we;
    mem_nxt.res_from_mem = id.res_from_mem;
    mem_nxt.gr_we        = id.gr_we;
    mem_nxt.rkd_value    = id.rkd_value;
    mem_nxt.rf_waddr     = id.rf_waddr;
    mem_nxt.ex_result    = ex_result;
  end

  // MEM accepting while we are not ready means it gets a bubble
  always_ff @(posedge clk) begin
    if (rst)                  mem_q <= '0;
    else if (bus.MEM_allowin) mem_q <= ready_go ? mem_nxt : '0;
  end

  assign bus.EX_to_MEM_reg = mem_q;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed corner cases plus random single-cycle
// and divide traffic against an arithmetic reference model.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if bus();
  ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic         f_valid, f_mwe, f_rfm, f_gwe;
  logic [31:0]  f_pc, f_ir, f_s1, f_s2, f_rkd;
  logic [11:0]  f_alu;
  logic [3:0]   f_div;
  logic [2:0]   f_mul, f_st;
  logic [4:0]   f_ld, f_wa;
  logic [144:0] mdl_reg;

  task automatic drive();
    bus.ID_to_EX_zip = {f_valid, f_pc, f_ir, f_alu, f_div, f_mul, f_s1, f_s2,
                        f_ld, f_st, f_mwe, f_rfm, f_gwe, f_rkd, f_wa};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bundle();
    f_valid = 0; f_pc = 0; f_ir = 0; f_alu = 0; f_div = 0; f_mul = 0; f_s1 = 0; f_s2 = 0;
    f_ld = 0; f_st = 0; f_mwe = 0; f_rfm = 0; f_gwe = 0; f_rkd = 0; f_wa = 0;
    drive();
  endtask

  task automatic rand_side();
    f_pc = $urandom; f_ir = $urandom; f_rkd = $urandom;
    f_ld = 5'($urandom); f_st = 3'($urandom); f_mwe = 1'($urandom);
    f_rfm = 1'b0; f_gwe = 1'b1; f_wa = 5'($urandom);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [144:0] exp_reg(input logic [31:0] res);
    return {f_valid, f_pc, f_ir, f_ld, f_st, f_mwe, f_rfm, f_gwe, f_rkd, f_wa, res};
  endfunction

  // Reference: plain integer arithmetic on the architectural definitions
  function automatic logic [31:0] ref_result(input logic [11:0] alu, input logic [3:0] dv,
                                             input logic [2:0] ml, input logic [31:0] a,
                                             input logic [31:0] b);
    int          sa, sb;
    longint      sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    if (dv != 0) begin
      if (b == 0) return (dv[2] | dv[0]) ? a : 32'hFFFF_FFFF;
      if (dv[3] | dv[2]) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return dv[3] ? 32'h8000_0000 : 32'h0;
        return dv[3] ? 32'(sa / sb) : 32'(sa % sb);
      end
      return dv[1] ? a / b : a % b;
    end
    if (ml != 0) begin
      if (ml[0]) begin
        up = {32'd0, a} * {32'd0, b};
        return up[63:32];
      end
      sp = longint'(sa) * longint'(sb);
      return ml[2] ? sp[31:0] : sp[63:32];
    end
    if (alu[1])  return a - b;
    if (alu[2])  return (sa < sb) ? 32'd1 : 32'd0;
    if (alu[3])  return (a < b) ? 32'd1 : 32'd0;
    if (alu[4])  return a & b;
    if (alu[5])  return ~(a | b);
    if (alu[6])  return a | b;
    if (alu[7])  return a ^ b;
    if (alu[8])  return a << b[4:0];
    if (alu[9])  return a >> b[4:0];
    if (alu[10]) return 32'(sa >>> b[4:0]);
    if (alu[11]) return b;
    return a + b;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.MEM_allowin = 1'b1;
    clear_bundle();
    tick();
    tick();
    checks++;
    if (bus.EX_to_MEM_reg !== '0) begin
      errors++; $display("FAIL reset_reg got=%h want=0", bus.EX_to_MEM_reg);
    end
    checks++;
    if (bus.EX_allowin !== 1'b1) begin
      errors++; $display("FAIL reset_allowin got=%b want=1", bus.EX_allowin);
    end
    checks++;
    if ({bus.front_valid, bus.front_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_front got=%b%b want=00", bus.front_valid, bus.front_busy);
    end
    rst = 1'b0;
    mdl_reg = '0;
  endtask

  task automatic test_add();
    rand_side();
    f_valid = 1; f_alu = 12'h001; f_div = 0; f_mul = 0;
    f_s1 = 32'h7FFF_FFFF; f_s2 = 32'h1; f_gwe = 1; f_rfm = 0; f_wa = 5'd5;
    drive();
    #1;
    checks++;
    if ({bus.front_valid, bus.front_busy, bus.EX_allowin, bus.front_addr, bus.front_data} !==
        {1'b1, 1'b0, 1'b1, 5'd5, 32'h8000_0000}) begin
      errors++;
      $display("FAIL add_front got fv=%b fb=%b ea=%b addr=%0d data=%h want fv=1 fb=0 ea=1 addr=5 data=80000000",
               bus.front_valid, bus.front_busy, bus.EX_allowin, bus.front_addr, bus.front_data);
    end
    tick();
    mdl_reg = exp_reg(32'h8000_0000);
    checks++;
    if (bus.EX_to_MEM_reg !== mdl_reg) begin
      errors++; $display("FAIL add_reg got=%h want=%h", bus.EX_to_MEM_reg, mdl_reg);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ta [6] = '{12'h400, 12'h004, 12'h008, 12'h000, 12'h000, 12'h000};
    logic [2:0]  tm [6] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100};
    logic [31:0] t1 [6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000};
    logic [31:0] t2 [6] = '{32'h21, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000};
    logic [31:0] tw [6] = '{32'hC000_0000, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0};
    bus.MEM_allowin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_side();
      f_valid = 1; f_alu = ta[i]; f_mul = tm[i]; f_div = 0; f_s1 = t1[i]; f_s2 = t2[i];
      drive();
      #1;
      checks++;
      if (bus.EX_allowin !== 1'b1 || bus.front_data !== tw[i]) begin
        errors++;
        $display("FAIL b2b_front[%0d] got ea=%b data=%h want ea=1 data=%h",
                 i, bus.EX_allowin, bus.front_data, tw[i]);
      end
      tick();
      mdl_reg = exp_reg(tw[i]);
      checks++;
      if (bus.EX_to_MEM_reg !== mdl_reg) begin
        errors++; $display("FAIL b2b_reg[%0d] got=%h want=%h", i, bus.EX_to_MEM_reg, mdl_reg);
      end
    end
  endtask

  task automatic test_random();
    logic        mem;
    logic [31:0] res;
    for (int i = 0; i < 300; i++) begin
      rand_side();
      f_valid = ($urandom_range(0, 7) != 0);
      f_alu = 0; f_mul = 0; f_div = 0;
      case ($urandom_range(0, 3))
        0: f_alu = 12'd1 << $urandom_range(0, 11);
        1: f_mul = 3'd1 << $urandom_range(0, 2);
        default: ;
      endcase
      f_s1 = rand_operand(); f_s2 = rand_operand();
      f_gwe = 1'($urandom); f_rfm = 1'($urandom);
      mem = ($urandom_range(0, 3) != 0);
      bus.MEM_allowin = mem;
      drive();
      #1;
      res = ref_result(f_alu, f_div, f_mul, f_s1, f_s2);
      checks++;
      if ({bus.front_valid, bus.front_busy, bus.EX_allowin, bus.front_addr, bus.front_data} !==
          {f_valid & f_gwe & ~f_rfm, f_valid & f_gwe & f_rfm, ~f_valid | mem, f_wa, res}) begin
        errors++;
        $display("FAIL rand_front[%0d] alu=%h mul=%b a=%h b=%h got fv=%b fb=%b ea=%b addr=%0d data=%h want data=%h",
                 i, f_alu, f_mul, f_s1, f_s2, bus.front_valid, bus.front_busy, bus.EX_allowin,
                 bus.front_addr, bus.front_data, res);
      end
      tick();
      if (mem) mdl_reg = f_valid ? exp_reg(res) : '0;
      checks++;
      if (bus.EX_to_MEM_reg !== mdl_reg) begin
        errors++; $display("FAIL rand_reg[%0d] got=%h want=%h", i, bus.EX_to_MEM_reg, mdl_reg);
      end
    end
  endtask

  task automatic test_div();
    logic [3:0]  td [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [31:0] t1 [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h5, 32'h5, 32'h8000_0000};
    logic [31:0] t2 [5] = '{32'h2, 32'h2, 32'h0, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] tw [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h8000_0000};
    logic [31:0] want;
    int          stall;
    bus.MEM_allowin = 1'b1;
    for (int i = 0; i < 11; i++) begin
      rand_side();
      f_valid = 1; f_alu = 0; f_mul = 0;
      if (i < 5) begin
        f_div = td[i]; f_s1 = t1[i]; f_s2 = t2[i]; want = tw[i];
      end else begin
        f_div = 4'd1 << $urandom_range(0, 3);
        f_s1 = rand_operand(); f_s2 = rand_operand();
        want = ref_result(f_alu, f_div, f_mul, f_s1, f_s2);
      end
      drive();
      #1;
      stall = 0;
      while (bus.EX_allowin !== 1'b1 && stall < 40) begin
        checks++;
        if (bus.front_busy !== 1'b1 || bus.front_valid !== 1'b0) begin
          errors++; $display("FAIL div_busy[%0d] cyc=%0d got fb=%b fv=%b want fb=1 fv=0",
                             i, stall, bus.front_busy, bus.front_valid);
        end
        if (stall > 0) begin
          checks++;
          if (bus.EX_to_MEM_reg !== '0) begin
            errors++; $display("FAIL div_bubble[%0d] cyc=%0d got=%h want=0", i, stall, bus.EX_to_MEM_reg);
          end
        end
        stall++;
        tick();
      end
      checks++;
      if (stall !== 33) begin
        errors++; $display("FAIL div_latency[%0d] got=%0d want=33", i, stall);
      end
      checks++;
      if (bus.front_valid !== 1'b1 || bus.front_data !== want) begin
        errors++; $display("FAIL div_result[%0d] op=%b a=%h b=%h got fv=%b data=%h want fv=1 data=%h",
                           i, f_div, f_s1, f_s2, bus.front_valid, bus.front_data, want);
      end
      tick();
      mdl_reg = exp_reg(want);
      checks++;
      if (bus.EX_to_MEM_reg !== mdl_reg) begin
        errors++; $display("FAIL div_reg[%0d] got=%h want=%h", i, bus.EX_to_MEM_reg, mdl_reg);
      end
      clear_bundle();
    end
  endtask

  task automatic test_div_hold();
    logic [31:0] want;
    bus.MEM_allowin = 1'b1;
    rand_side();
    f_valid = 1; f_alu = 0; f_mul = 0; f_div = 4'b1000;
    f_s1 = $urandom; f_s2 = $urandom | 32'h10;
    want = ref_result(f_alu, f_div, f_mul, f_s1, f_s2);
    drive();
    tick();
    tick();
    // operands are latched at start; ID-side changes during BUSY must not matter
    f_s1 = $urandom; f_s2 = $urandom;
    drive();
    repeat (31) tick();
    bus.MEM_allowin = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus.front_valid, bus.EX_allowin, bus.front_data, bus.EX_to_MEM_reg} !==
          {1'b1, 1'b0, want, 145'd0}) begin
        errors++; $display("FAIL hold[%0d] got fv=%b ea=%b data=%h reg=%h want fv=1 ea=0 data=%h reg=0",
                           k, bus.front_valid, bus.EX_allowin, bus.front_data, bus.EX_to_MEM_reg, want);
      end
      tick();
    end
    bus.MEM_allowin = 1'b1;
    #1;
    checks++;
    if (bus.EX_allowin !== 1'b1) begin
      errors++; $display("FAIL hold_release got ea=%b want=1", bus.EX_allowin);
    end
    tick();
    mdl_reg = exp_reg(want);
    checks++;
    if (bus.EX_to_MEM_reg !== mdl_reg) begin
      errors++; $display("FAIL hold_reg got=%h want=%h", bus.EX_to_MEM_reg, mdl_reg);
    end
    clear_bundle();
  endtask

  task automatic test_div_reset();
    logic [31:0] want;
    int          stall;
    bus.MEM_allowin = 1'b1;
    rand_side();
    f_valid = 1; f_alu = 0; f_mul = 0; f_div = 4'b0100; f_s1 = $urandom; f_s2 = $urandom | 32'h1;
    drive();
    repeat (10) tick();
    rst = 1'b1;
    clear_bundle();
    tick();
    rst = 1'b0;
    #1;
    mdl_reg = '0;
    checks++;
    if ({bus.EX_to_MEM_reg, bus.EX_allowin, bus.front_busy} !== {145'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rst_mid_div got reg=%h ea=%b fb=%b want reg=0 ea=1 fb=0",
                         bus.EX_to_MEM_reg, bus.EX_allowin, bus.front_busy);
    end
    // a fresh divide after the reset must run the full sequence from IDLE
    rand_side();
    f_valid = 1; f_div = 4'b0010; f_s1 = $urandom; f_s2 = $urandom_range(1, 1000);
    want = ref_result(f_alu, f_div, f_mul, f_s1, f_s2);
    drive();
    #1;
    stall = 0;
    while (bus.EX_allowin !== 1'b1 && stall < 40) begin
      stall++;
      tick();
    end
    checks++;
    if (stall !== 33 || bus.front_data !== want) begin
      errors++; $display("FAIL rst_redo got stall=%0d data=%h want stall=33 data=%h",
                         stall, bus.front_data, want);
    end
    tick();
    mdl_reg = exp_reg(want);
    checks++;
    if (bus.EX_to_MEM_reg !== mdl_reg) begin
      errors++; $display("FAIL rst_redo_reg got=%h want=%h", bus.EX_to_MEM_reg, mdl_reg);
    end
    clear_bundle();
  endtask

  initial begin
    rst = 1'b1;
    bus.MEM_allowin = 1'b1;
    clear_bundle();
    mdl_reg = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_random();
    test_div();
    test_div_hold();
    test_div_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
